gpio_dglitch_ctrl: RTL and testbench
====================================

# gpio_dglitch_ctrl

GPIO input conditioning controller between the pad-side GPIO inputs and the GPIO register block. It generates the programmable 1 us sampling tick and synchronizes and de-glitches every input pin. Per pin, filtering is selectable between tick-rate and every-clock sampling. Filtered edges are turned into sticky, maskable interrupt status with a single combined interrupt request.

## Interface
- NPIN, 32, number of GPIO pins handled
- PRESC_W, 8, width of prescaler configuration
- mclk  input  1  system clock; the only clock
- reset  input  1  asynchronous, active-high reset
- cfg_prescale  input  PRESC_W  tick period minus one, in mclk cycles (e.g. 49 for 50 MHz)
- cfg_mode  input  NPIN  per pin: 0 = sample on 1 us tick, 1 = sample every mclk
- cfg_int_rise  input  NPIN  per pin rising-edge interrupt enable
- cfg_int_fall  input  NPIN  per pin falling-edge interrupt enable
- cfg_int_mask  input  NPIN  per pin irq enable (1 = contributes to irq)
- int_clr  input  NPIN  write-one-to-clear pulses for int_status
- gpio_in  input  NPIN  asynchronous pad inputs
- gpio_out  output  NPIN  synchronized, de-glitched pin values
- pulse_1us  output  1  one-mclk-wide sampling tick
- int_status  output  NPIN  sticky edge status
- irq  output  1  OR of (int_status & cfg_int_mask), registered

## Operation
- Reset, asynchronous: all internal and output flops go to 0.
  - prescale counter = 0; pulse_1us, gpio_out, int_status, irq = 0.
  - Synchronizer and sample shift registers = 0.
- Prescaler:
  - cnt increments each mclk.
  - When cnt >= cfg_prescale: pulse_1us = 1 for that cycle, and cnt reloads 0 at the next edge.
  - cfg_prescale = 0 gives pulse_1us permanently high.
  - Lowering cfg_prescale below the current cnt gives a tick on the next cycle, with no wrap through the full range.
- Per pin datapath:
  - Two-flop synchronizer s1 -> s2.
  - Then a 3-bit sample shift ss[2:0] <= {ss[1:0], s2}.
  - The shift occurs every cycle when cfg_mode = 1, or only when the registered pulse_1us is high when cfg_mode = 0.
- Filter:
  - gpio_out register loads ss[2] when ss[2] == ss[1] == ss[0]; otherwise it holds.
  - A value must therefore be seen on three consecutive samples before it is accepted.
- Edge detect, evaluated at the edge where gpio_out updates:
  - rise = new 1, old 0; fall = new 0, old 1.
  - int_status[i] sets on (rise & cfg_int_rise[i]) | (fall & cfg_int_fall[i]).
- Clear:
  - int_clr[i] = 1 clears int_status[i] at the next edge.
  - A set and a clear in the same cycle: set wins, so status stays 1.
- irq <= |(int_status & cfg_int_mask), registered from the current int_status.
- cfg_mode changing mid-filter: the ss contents are kept, and sampling continues at the new rate. No flush is done.

## Timing
- Tick period = cfg_prescale + 1 mclk cycles. The first pulse_1us after reset release is on cycle cfg_prescale (0-based).
- Mode 1 latency: gpio_in captured by s1 at edge k gives gpio_out updated after edge k+5. int_status sets at the same edge k+5, and irq rises at edge k+6.
- Mode 1 glitch rejection: any input pulse shorter than 3 mclk cycles at s2 is rejected.
- Mode 0 latency: 2 cycles (sync) + 3 ticks + 1 cycle. A level must be stable across 3 consecutive ticks.
- All outputs are registered. There is no combinational path from inputs to outputs.
- Reset asserted mid-operation: every output drops to 0 within the same cycle, asynchronously. After release, a pin held high produces a rising edge (status set if enabled), because gpio_out restarts at 0.

## Test plan
- Prescaler:
  - cfg_prescale = 4 -> pulse_1us high every 5th cycle, first at cycle 4.
  - Change to 1 while cnt = 3 -> tick on the next cycle, then every 2 cycles.
- Mode 1, pin 0: gpio_in[0] 0->1 held, cfg_int_rise[0] = 1, cfg_int_mask[0] = 1 -> gpio_out[0] = 1 and int_status[0] = 1 after 5 edges; irq = 1 one cycle later.
- Glitch rejection, mode 1: a 2-cycle-wide high pulse on gpio_in[3] -> gpio_out[3] stays 0 and int_status[3] stays 0. Repeat with a 3-cycle pulse -> gpio_out[3] goes 1 then back to 0, and a fall edge is flagged if enabled.
- Mode 0, cfg_prescale = 9, gpio_in[7] high for 25 cycles -> no change. High for 40 cycles -> gpio_out[7] goes to 1 after the third tick sampling 1.
- Clear race: drive int_clr[5] in the same cycle as a new fall event on pin 5 -> int_status[5] remains 1. A separate int_clr[5] pulse -> 0, and irq drops the following cycle.
- Reset mid-operation: assert reset with int_status = 0xFFFF_FFFF and pulses running -> all outputs 0 immediately. Release with gpio_in = all ones and rise enabled -> int_status = all ones after 5 edges.

Source files
------------

// File: rtl/gpio_dglitch_ctrl_if.sv
// Bus bundle between the GPIO register block (master) and the input conditioning
// controller (slave): configuration, pad inputs and conditioned outputs.
interface gpio_dglitch_ctrl_if #(
    parameter int unsigned NPIN    = 32,
    parameter int unsigned PRESC_W = 8
);
    logic [PRESC_W-1:0] cfg_prescale;
    logic [NPIN-1:0]    cfg_mode;
    logic [NPIN-1:0]    cfg_int_rise;
    logic [NPIN-1:0]    cfg_int_fall;
    logic [NPIN-1:0]    cfg_int_mask;
    logic [NPIN-1:0]    int_clr;
    logic [NPIN-1:0]    gpio_in;
    logic [NPIN-1:0]    gpio_out;
    logic               pulse_1us;
    logic [NPIN-1:0]    int_status;
    logic               irq;

    modport master (
        output cfg_prescale,
        output cfg_mode,
        output cfg_int_rise,
        output cfg_int_fall,
        output cfg_int_mask,
        output int_clr,
        output gpio_in,
        input  gpio_out,
        input  pulse_1us,
        input  int_status,
        input  irq
    );

    modport slave (
        input  cfg_prescale,
        input  cfg_mode,
        input  cfg_int_rise,
        input  cfg_int_fall,
        input  cfg_int_mask,
        input  int_clr,
        input  gpio_in,
        output gpio_out,
        output pulse_1us,
        output int_status,
        output irq
    );
endinterface

// File: rtl/gpio_dglitch_ctrl.sv
// GPIO input conditioning: 1 us sampling tick, per-pin two-flop synchronizer, 3-sample
// majority-free (all-equal) filter, and sticky maskable edge interrupts.
module gpio_dglitch_ctrl #(
    parameter int unsigned NPIN    = 32,
    parameter int unsigned PRESC_W = 8
) (
    input logic                mclk,
    input logic                reset,
    gpio_dglitch_ctrl_if.slave bus
);

    logic [PRESC_W-1:0] cnt_q, cnt_d;
    logic               pulse_q, pulse_d;

    logic [NPIN-1:0] s1_q, s2_q;
    logic [NPIN-1:0] ss0_q, ss1_q, ss2_q;
    logic [NPIN-1:0] ss0_d, ss1_d, ss2_d;
    logic [NPIN-1:0] shift_en, settled;
    logic [NPIN-1:0] out_q, out_d;
    logic [NPIN-1:0] rise, fall;
    logic [NPIN-1:0] status_q, status_d;
    logic            irq_q, irq_d;

    // The counter reloads only after a tick was actually issued, so lowering the
    // prescale below the running count yields a tick on the very next cycle.
    always_comb begin
        cnt_d   = pulse_q ? '0 : cnt_q + 1'b1;
        pulse_d = (cnt_d >= bus.cfg_prescale);
    end

    always_comb begin
        shift_en = bus.cfg_mode | {NPIN{pulse_q}};
        ss0_d    = (shift_en & s2_q)  | (~shift_en & ss0_q);
        ss1_d    = (shift_en & ss0_q) | (~shift_en & ss1_q);
        ss2_d    = (shift_en & ss1_q) | (~shift_en & ss2_q);

        settled  = ~(ss2_q ^ ss1_q) & ~(ss1_q ^ ss0_q);
        out_d    = (settled & ss2_q) | (~settled & out_q);

        rise     = out_d & ~out_q;
        fall     = out_q & ~out_d;
        // New events are ORed in after the clear, so a coincident set survives.
        status_d = (status_q & ~bus.int_clr)
                 | (rise & bus.cfg_int_rise)
                 | (fall & bus.cfg_int_fall);
        irq_d    = |(status_q & bus.cfg_int_mask);
    end

    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            cnt_q    <= '0;
            pulse_q  <= 1'b0;
            s1_q     <= '0;
            s2_q     <= '0;
            ss0_q    <= '0;
            ss1_q    <= '0;
            ss2_q    <= '0;
            out_q    <= '0;
            status_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            pulse_q  <= pulse_d;
            s1_q     <= bus.gpio_in;
            s2_q     <= s1_q;
            ss0_q    <= ss0_d;
            ss1_q    <= ss1_d;
            ss2_q    <= ss2_d;
            out_q    <= out_d;
            status_q <= status_d;
            irq_q    <= irq_d;
        end
    end

    assign bus.gpio_out   = out_q;
    assign bus.pulse_1us  = pulse_q;
    assign bus.int_status = status_q;
    assign bus.irq        = irq_q;

endmodule

// File: tb/tb_gpio_dglitch_ctrl.sv
// Self-checking bench for gpio_dglitch_ctrl: glitch vector table, directed timing
// sequences, and randomized traffic against a run-length based reference model.
module tb_gpio_dglitch_ctrl;

    logic mclk;
    logic reset;

    gpio_dglitch_ctrl_if #(.NPIN(32), .PRESC_W(8)) bus ();

    gpio_dglitch_ctrl #(.NPIN(32), .PRESC_W(8)) dut (
        .mclk  (mclk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        mclk = 1'b0;
        forever #5 mclk = ~mclk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int   pin;
        int   width;
        logic rise_en;
        logic fall_en;
        logic exp_high;
        logic exp_status;
    } glitch_vec_t;

    glitch_vec_t gv[6];

    // Reference model state
    logic [31:0] m_d1, m_d2, m_out, m_status, m_val;
    logic [31:0] m_rise, m_fall, m_mask;
    logic        m_irq;
    int          m_len[32];
    int          m_p;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge mclk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1);
        reset = 1'b0;
    endtask

    task automatic cfg_all(input int p, input logic [31:0] mode, input logic [31:0] rise,
                           input logic [31:0] fall, input logic [31:0] mask);
        bus.cfg_prescale = 8'(p);
        bus.cfg_mode     = mode;
        bus.cfg_int_rise = rise;
        bus.cfg_int_fall = fall;
        bus.cfg_int_mask = mask;
        bus.int_clr      = '0;
        bus.gpio_in      = '0;
    endtask

    // Tick in cycle c (c = edges since reset release) for a tick period of p+1.
    function automatic logic model_tick(input int p, input int c);
        if (c < 1) return 1'b0;
        if (p == 0) return 1'b1;
        return (c >= p) && (((c - p) % (p + 1)) == 0);
    endfunction

    task automatic model_reset();
        m_d1 = '0; m_d2 = '0; m_out = '0; m_status = '0; m_val = '0; m_irq = 1'b0;
        for (int i = 0; i < 32; i++) m_len[i] = 3;
    endtask

    // One clock edge: accepted value follows a run of three equal samples.
    task automatic model_step(input int c, input logic [31:0] din, input logic [31:0] clr,
                              input logic [31:0] mode);
        logic [31:0] out_new, rise, fall, smp;
        logic        tk;
        tk  = model_tick(m_p, c);
        smp = m_d2;
        for (int i = 0; i < 32; i++) out_new[i] = (m_len[i] >= 3) ? m_val[i] : m_out[i];
        rise     = out_new & ~m_out;
        fall     = m_out & ~out_new;
        m_irq    = |(m_status & m_mask);
        m_status = (m_status & ~clr) | (rise & m_rise) | (fall & m_fall);
        m_out    = out_new;
        for (int i = 0; i < 32; i++) begin
            if (mode[i] || tk) begin
                if (smp[i] == m_val[i]) begin
                    if (m_len[i] < 3) m_len[i]++;
                end else begin
                    m_val[i] = smp[i];
                    m_len[i] = 1;
                end
            end
        end
        m_d2 = m_d1;
        m_d1 = din;
    endtask

    initial begin
        logic [31:0] cur_in, cur_clr, cur_mode;
        logic        saw;

        gv[0] = '{pin: 3,  width: 2, rise_en: 1'b1, fall_en: 1'b1, exp_high: 1'b0, exp_status: 1'b0};
        gv[1] = '{pin: 3,  width: 3, rise_en: 1'b0, fall_en: 1'b1, exp_high: 1'b1, exp_status: 1'b1};
        gv[2] = '{pin: 3,  width: 3, rise_en: 1'b0, fall_en: 1'b0, exp_high: 1'b1, exp_status: 1'b0};
        gv[3] = '{pin: 9,  width: 1, rise_en: 1'b1, fall_en: 1'b1, exp_high: 1'b0, exp_status: 1'b0};
        gv[4] = '{pin: 9,  width: 5, rise_en: 1'b1, fall_en: 1'b0, exp_high: 1'b1, exp_status: 1'b1};
        gv[5] = '{pin: 31, width: 4, rise_en: 1'b0, fall_en: 1'b0, exp_high: 1'b1, exp_status: 1'b0};

        // Reset state
        cfg_all(4, '1, '1, '1, '1);
        bus.gpio_in = '1;
        reset = 1'b1;
        step(3);
        check("reset gpio_out", bus.gpio_out, '0);
        check("reset int_status", bus.int_status, '0);
        check("reset irq", 32'(bus.irq), 0);
        check("reset pulse", 32'(bus.pulse_1us), 0);

        // Prescaler: period 5, then lowered to 1 while the count is 3
        cfg_all(4, '0, '0, '0, '0);
        do_reset();
        check("presc c0", 32'(bus.pulse_1us), 0);
        for (int c = 1; c <= 13; c++) begin
            step(1);
            check($sformatf("presc4 c%0d", c), 32'(bus.pulse_1us), 32'((c == 4) || (c == 9)));
        end
        bus.cfg_prescale = 8'd1;
        for (int c = 14; c <= 19; c++) begin
            step(1);
            check($sformatf("presc1 c%0d", c), 32'(bus.pulse_1us), 32'((c % 2) == 0));
        end

        // Mode 1 latency on pin 0
        cfg_all(4, '1, 32'h1, '0, 32'h1);
        do_reset();
        step(2);
        bus.gpio_in[0] = 1'b1;
        step(5);
        check("lat e+4 gpio_out", 32'(bus.gpio_out[0]), 0);
        check("lat e+4 status", 32'(bus.int_status[0]), 0);
        step(1);
        check("lat e+5 gpio_out", 32'(bus.gpio_out[0]), 1);
        check("lat e+5 status", 32'(bus.int_status[0]), 1);
        check("lat e+5 irq", 32'(bus.irq), 0);
        step(1);
        check("lat e+6 irq", 32'(bus.irq), 1);

        // Glitch table, mode 1
        for (int v = 0; v < 6; v++) begin
            cfg_all(3, '1, 32'(gv[v].rise_en) << gv[v].pin, 32'(gv[v].fall_en) << gv[v].pin,
                    32'h1 << gv[v].pin);
            do_reset();
            step(3);
            bus.gpio_in[gv[v].pin] = 1'b1;
            step(gv[v].width);
            bus.gpio_in = '0;
            saw = 1'b0;
            for (int k = 0; k < 12; k++) begin
                step(1);
                saw = saw | bus.gpio_out[gv[v].pin];
            end
            check($sformatf("glitch%0d seen high", v), 32'(saw), 32'(gv[v].exp_high));
            check($sformatf("glitch%0d status", v), 32'(bus.int_status[gv[v].pin]),
                  32'(gv[v].exp_status));
            check($sformatf("glitch%0d irq", v), 32'(bus.irq), 32'(gv[v].exp_status));
            check($sformatf("glitch%0d final out", v), bus.gpio_out, '0);
        end

        // Mode 0, tick period 10: 25 cycles high is rejected
        cfg_all(9, '0, 32'h80, '0, 32'h80);
        do_reset();
        step(12);
        bus.gpio_in[7] = 1'b1;
        saw = 1'b0;
        for (int k = 0; k < 25; k++) begin
            step(1);
            saw = saw | bus.gpio_out[7];
        end
        bus.gpio_in[7] = 1'b0;
        for (int k = 0; k < 30; k++) begin
            step(1);
            saw = saw | bus.gpio_out[7];
        end
        check("mode0 25cyc rejected", 32'(saw), 0);

        // Mode 0: 40 cycles high is accepted after the third tick sampling 1
        cfg_all(9, '0, 32'h80, '0, 32'h80);
        do_reset();
        step(12);
        bus.gpio_in[7] = 1'b1;
        step(28);
        check("mode0 c40 gpio_out", 32'(bus.gpio_out[7]), 0);
        step(1);
        check("mode0 c41 gpio_out", 32'(bus.gpio_out[7]), 1);
        check("mode0 c41 status", 32'(bus.int_status[7]), 1);
        step(11);
        bus.gpio_in[7] = 1'b0;

        // Clear race on pin 5
        cfg_all(4, '1, 32'h20, 32'h20, 32'h20);
        do_reset();
        step(1);
        bus.gpio_in[5] = 1'b1;
        step(8);
        check("race pre status", 32'(bus.int_status[5]), 1);
        bus.gpio_in[5] = 1'b0;
        step(5);
        check("race pre out", 32'(bus.gpio_out[5]), 1);
        bus.int_clr[5] = 1'b1;
        step(1);
        bus.int_clr[5] = 1'b0;
        check("race out fell", 32'(bus.gpio_out[5]), 0);
        check("race set wins", 32'(bus.int_status[5]), 1);
        step(2);
        bus.int_clr[5] = 1'b1;
        step(1);
        bus.int_clr[5] = 1'b0;
        check("clr status", 32'(bus.int_status[5]), 0);
        check("clr irq still high", 32'(bus.irq), 1);
        step(1);
        check("clr irq drops", 32'(bus.irq), 0);

        // Reset mid-operation
        cfg_all(2, '1, '1, '1, '1);
        do_reset();
        bus.gpio_in = '1;
        step(8);
        check("midrst pre status", bus.int_status, 32'hFFFF_FFFF);
        check("midrst pre irq", 32'(bus.irq), 1);
        #2;
        reset = 1'b1;
        #1;
        check("midrst gpio_out", bus.gpio_out, '0);
        check("midrst status", bus.int_status, '0);
        check("midrst irq", 32'(bus.irq), 0);
        check("midrst pulse", 32'(bus.pulse_1us), 0);
        step(1);
        reset = 1'b0;
        step(5);
        check("postrst e5 status", bus.int_status, '0);
        step(1);
        check("postrst e6 status", bus.int_status, 32'hFFFF_FFFF);
        check("postrst e6 gpio_out", bus.gpio_out, 32'hFFFF_FFFF);

        // Randomized traffic against the reference model
        for (int r = 0; r < 2; r++) begin
            m_p      = int'($urandom_range(0, 6));
            m_rise   = $urandom;
            m_fall   = $urandom;
            m_mask   = $urandom;
            cur_mode = $urandom;
            cfg_all(m_p, cur_mode, m_rise, m_fall, m_mask);
            cur_in   = '0;
            do_reset();
            model_reset();
            for (int c = 0; c < 600; c++) begin
                if ($urandom_range(0, 99) == 0) cur_mode = $urandom;
                cur_in  = cur_in ^ ($urandom & $urandom & $urandom);
                cur_clr = $urandom & $urandom & $urandom & $urandom;
                bus.cfg_mode = cur_mode;
                bus.gpio_in  = cur_in;
                bus.int_clr  = cur_clr;
                step(1);
                model_step(c, cur_in, cur_clr, cur_mode);
                check("rnd gpio_out", bus.gpio_out, m_out);
                check("rnd int_status", bus.int_status, m_status);
                check("rnd irq", 32'(bus.irq), 32'(m_irq));
                check("rnd pulse", 32'(bus.pulse_1us), 32'(model_tick(m_p, c + 1)));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
